// File: rtl/obs_field.sv
// Multi-lane falling obstacle manager: per-lane position/state, bullet kills,
// lower-limit crossings, frame-counted respawn and pixel draw.
module obs_field #(
   parameter int NUM_OBS        = 4,
   parameter int OBS_W          = 20,
   parameter int OBS_H          = 20,
   parameter int LANE_X0        = 70,
   parameter int LANE_PITCH     = 160,
   parameter int FRAC           = 4,
   parameter int START_Y        = 0,
   parameter int LOWER_LIMIT    = 475,
   parameter int RESPAWN_FRAMES = 60
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               video_on,
   input  logic [10:0]        pix_x,
   input  logic [10:0]        pix_y,
   input  logic [10:0]        bull_x,
   input  logic [10:0]        bull_y,
   input  logic [3:0]         speed,
   input  logic               enable,
   output logic [2:0]         rgb,
   output logic               obs_on,
   output logic [NUM_OBS-1:0] alive_mask,
   output logic               hit_pulse,
   output logic               crossed_pulse,
   output logic [7:0]         hit_count
);

   localparam int YW = 11 + FRAC;
   localparam logic [YW-1:0] Y0 = YW'(START_Y << FRAC);
   localparam logic [7:0] RESP = 8'(RESPAWN_FRAMES);

   logic [YW-1:0]      y_q [NUM_OBS];
   logic [YW-1:0]      y_d [NUM_OBS];
   logic [7:0]         dc_q [NUM_OBS];
   logic [7:0]         dc_d [NUM_OBS];
   logic [NUM_OBS-1:0] alive_q, alive_d;
   logic               hit_q, hit_d;
   logic               crs_q, crs_d;
   logic [7:0]         cnt_q, cnt_d;

   logic [11:0]        xl [NUM_OBS];
   logic [11:0]        xr [NUM_OBS];
   logic [11:0]        yt [NUM_OBS];
   logic [11:0]        yb [NUM_OBS];
   logic [NUM_OBS-1:0] col, on;
   logic [11:0]        px, py, bx, by;
   logic               frame_tick, step;

   assign px = {1'b0, pix_x};
   assign py = {1'b0, pix_y};
   assign bx = {1'b0, bull_x};
   assign by = {1'b0, bull_y};

   assign frame_tick = (pix_y == 11'd481) && (pix_x == 11'd0);
   assign step       = frame_tick & enable;

   // Lane geometry is fixed; only the top edge moves.
   always_comb begin
      for (int i = 0; i < NUM_OBS; i++) begin
         xl[i]  = 12'(LANE_X0 + i * LANE_PITCH);
         xr[i]  = xl[i] + 12'(OBS_W - 1);
         yt[i]  = {1'b0, y_q[i][YW-1:FRAC]};
         yb[i]  = yt[i] + 12'(OBS_H - 1);
         on[i]  = alive_q[i] &&
                  (px >= xl[i]) && (px <= xr[i]) &&
                  (py >= yt[i]) && (py <= yb[i]);
         col[i] = alive_q[i] &&
                  (bx > xl[i]) && (bx < xr[i]) &&
                  (by > yt[i]) && (by < yb[i]);
      end
   end

   always_comb begin
      alive_d = alive_q;
      hit_d   = |col;
      crs_d   = 1'b0;
      cnt_d   = cnt_q;
      for (int i = 0; i < NUM_OBS; i++) begin
         y_d[i]  = y_q[i];
         dc_d[i] = dc_q[i];
         if (alive_q[i]) begin
            if (col[i]) begin
               alive_d[i] = 1'b0;
               dc_d[i]    = RESP;
            end else if (step && (yb[i] >= 12'(LOWER_LIMIT))) begin
               alive_d[i] = 1'b0;
               dc_d[i]    = RESP;
               crs_d      = 1'b1;
            end else if (step) begin
               y_d[i] = y_q[i] + YW'(speed);
            end
         end else if (dc_q[i] == 8'd1) begin
            alive_d[i] = 1'b1;
            y_d[i]     = Y0;
         end else if (step && (dc_q[i] > 8'd1)) begin
            dc_d[i] = dc_q[i] - 8'd1;
         end
      end
      if ((|col) && (cnt_q != 8'hFF))
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         alive_q <= '1;
         hit_q   <= 1'b0;
         crs_q   <= 1'b0;
         cnt_q   <= 8'd0;
         for (int i = 0; i < NUM_OBS; i++) begin
            y_q[i]  <= Y0;
            dc_q[i] <= 8'd0;
         end
      end else begin
         alive_q <= alive_d;
         hit_q   <= hit_d;
         crs_q   <= crs_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < NUM_OBS; i++) begin
            y_q[i]  <= y_d[i];
            dc_q[i] <= dc_d[i];
         end
      end
   end

   assign obs_on        = |on;
   assign rgb           = (video_on && obs_on) ? 3'b111 : 3'b000;
   assign alive_mask    = alive_q;
   assign hit_pulse     = hit_q;
   assign crossed_pulse = crs_q;
   assign hit_count     = cnt_q;

endmodule
